// File: rtl/conf_regbank.sv
// conf_regbank: configuration register bank fed from a serial byte link.
// Received bytes shift through an rx chain. A commit copies a complete frame
// into the config registers. A tx shifter replays the config registers one
// byte at a time.
// Optional feature macro: CONF_REGBANK_CHECKSUM_EN. When it is defined, each
// frame carries one extra checksum byte, and the frame must sum to zero
// modulo 2^DW before a commit is accepted.
module conf_regbank #(
    parameter int NBYTES = 11,
    parameter int DW     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DW-1:0]        rx_dw,
    input  logic                 rx_valid,
    input  logic                 frame_start,
    input  logic                 commit,
    input  logic                 tx_load,
    input  logic                 tx_shift,
    output logic [DW-1:0]        tx_dw,
    output logic                 tx_empty,
    output logic [6:0]           rx_count,
    output logic [DW*NBYTES-1:0] conf_flat,
    output logic                 conf_valid,
    output logic                 commit_ok,
    output logic                 commit_err
);

`ifdef CONF_REGBANK_CHECKSUM_EN
    localparam int FLEN = NBYTES + 1;
`else
    localparam int FLEN = NBYTES;
`endif
    localparam logic [6:0] FLEN_C   = 7'(FLEN);
    localparam logic [6:0] NBYTES_C = 7'(NBYTES);

    logic [DW-1:0] rxChain_q [FLEN];
    logic [DW-1:0] rxChain_d [FLEN];
    logic [6:0]    rxCount_q, rxCount_d;
    logic [DW-1:0] conf_q [NBYTES];
    logic [DW-1:0] conf_d [NBYTES];
    logic [DW-1:0] txSlot_q [NBYTES];
    logic [DW-1:0] txSlot_d [NBYTES];
    logic [6:0]    txRemain_q, txRemain_d;
    logic          confValid_q, confValid_d;
    logic          commitOk_q, commitOk_d;
    logic          commitErr_q, commitErr_d;
    logic          csumOk;
    logic          commitAccept;

`ifdef CONF_REGBANK_CHECKSUM_EN
    logic [DW-1:0] csumSum;

    // Sum of every chain stage, including the checksum byte, wrapping at 2^DW
    always_comb begin
        csumSum = '0;
        for (int k = 0; k < FLEN; k++) begin
            csumSum = csumSum + rxChain_q[k];
        end
    end

    assign csumOk = (csumSum == '0);
`else
    assign csumOk = 1'b1;
`endif

    // A frame_start in the same cycle as a commit always turns the commit into a rejection
    assign commitAccept = commit && !frame_start && (rxCount_q == FLEN_C) && csumOk;

    // Next-state logic for the rx chain, byte count, config registers, tx shifter and status pulses
    always_comb begin
        rxChain_d   = rxChain_q;
        rxCount_d   = rxCount_q;
        conf_d      = conf_q;
        txSlot_d    = txSlot_q;
        txRemain_d  = txRemain_q;
        confValid_d = confValid_q;
        commitOk_d  = commitAccept;
        commitErr_d = commit && !commitAccept;

        if (rx_valid) begin
            for (int k = 0; k < FLEN - 1; k++) begin
                rxChain_d[k] = rxChain_q[k+1];
            end
            rxChain_d[FLEN-1] = rx_dw;
        end

        if (commit || frame_start) begin
            rxCount_d = rx_valid ? 7'd1 : 7'd0;
        end else if (rx_valid && (rxCount_q != FLEN_C)) begin
            rxCount_d = rxCount_q + 7'd1;
        end

        if (commitAccept) begin
            for (int i = 0; i < NBYTES; i++) begin
                conf_d[i] = rxChain_q[i];
            end
            confValid_d = 1'b1;
        end

        if (tx_load) begin
            txSlot_d   = conf_q;
            txRemain_d = NBYTES_C;
        end else if (tx_shift && (txRemain_q != 7'd0)) begin
            for (int i = 0; i < NBYTES - 1; i++) begin
                txSlot_d[i] = txSlot_q[i+1];
            end
            txSlot_d[NBYTES-1] = '0;
            txRemain_d = txRemain_q - 7'd1;
        end
    end

    // State registers; reset wins over every strobe and drops any partial frame
    always_ff @(posedge clk) begin
        if (rst) begin
            rxChain_q   <= '{default: '0};
            rxCount_q   <= '0;
            conf_q      <= '{default: '0};
            txSlot_q    <= '{default: '0};
            txRemain_q  <= '0;
            confValid_q <= 1'b0;
            commitOk_q  <= 1'b0;
            commitErr_q <= 1'b0;
        end else begin
            rxChain_q   <= rxChain_d;
            rxCount_q   <= rxCount_d;
            conf_q      <= conf_d;
            txSlot_q    <= txSlot_d;
            txRemain_q  <= txRemain_d;
            confValid_q <= confValid_d;
            commitOk_q  <= commitOk_d;
            commitErr_q <= commitErr_d;
        end
    end

    // Pack the config registers onto the flat output bus, byte i on bits [DW*i +: DW]
    always_comb begin
        conf_flat = '0;
        for (int i = 0; i < NBYTES; i++) begin
            conf_flat[DW*i +: DW] = conf_q[i];
        end
    end

    assign tx_dw      = txSlot_q[0];
    assign tx_empty   = (txRemain_q == 7'd0);
    assign rx_count   = rxCount_q;
    assign conf_valid = confValid_q;
    assign commit_ok  = commitOk_q;
    assign commit_err = commitErr_q;

endmodule

// File: doc/conf_regbank.md
CONF_REGBANK -- requirements
Module: conf_regbank

Interface
REQ-001 SHALL have parameter NBYTES, default 11: number of configuration bytes in one frame, range 2..64.
REQ-002 SHALL have parameter DW, default 8: byte width of the serial link.
REQ-003 SHALL have port clk  in  1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-005 SHALL have port rx_dw  in  DW: received byte from the RS232 receiver.
REQ-006 SHALL have port rx_valid  in  1: strobe meaning rx_dw is valid this cycle.
REQ-007 SHALL have port frame_start  in  1: strobe that discards the partial frame and clears the byte count.
REQ-008 SHALL have port commit  in  1: strobe requesting a copy of the rx frame into the config registers.
REQ-009 SHALL have port tx_load  in  1: strobe that copies the config registers into the tx shifter.
REQ-010 SHALL have port tx_shift  in  1: strobe that pops one byte from the tx shifter.
REQ-011 SHALL have port tx_dw  out  DW: current tx byte (tx slot 0).
REQ-012 SHALL have port tx_empty  out  1: high when the tx remaining count is 0.
REQ-013 SHALL have port rx_count  out  7: number of bytes received in the current frame.
REQ-014 SHALL have port conf_flat  out  DW*NBYTES: config byte i is on bits [DW*i+DW-1 : DW*i].
REQ-015 SHALL have port conf_valid  out  1: sticky flag, high after the first accepted commit.
REQ-016 SHALL have port commit_ok  out  1: one-cycle pulse when a commit is accepted.
REQ-017 SHALL have port commit_err  out  1: one-cycle pulse when a commit is rejected.

Function
REQ-018 SHALL store received bytes in a shift chain of FLEN stages: FLEN = NBYTES, or NBYTES+1 with the checksum feature.
- On rx_valid, rx_dw enters stage FLEN-1 and every stage k moves to stage k-1.
- After FLEN bytes, the first byte received sits in stage 0.
REQ-019 SHALL increment rx_count on each rx_valid, saturating at FLEN.
- Bytes received at saturation still shift the chain.
REQ-020 SHALL accept a commit only when rx_count == FLEN and the checksum rule (REQ-032) holds.
- Accept: copy stages 0..NBYTES-1 into the config registers, pulse commit_ok and set conf_valid, 1 cycle after commit.
- Otherwise: pulse commit_err and leave the config registers unchanged.
REQ-021 SHALL clear rx_count to 0 on every commit, whether accepted or rejected.
REQ-022 SHALL handle commit and rx_valid in the same cycle as follows:
- The commit evaluates the pre-update chain and count.
- The new byte is shifted in.
- rx_count becomes 1.
REQ-023 SHALL handle frame_start as follows:
- frame_start alone: rx_count becomes 0.
- frame_start with rx_valid: rx_count becomes 1.
- frame_start with commit: commit_err pulses and rx_count becomes 0.
REQ-024 SHALL, on tx_load, copy the config registers into tx slots 0..NBYTES-1 and set the tx remaining count to NBYTES.
REQ-025 SHALL, on tx_shift with tx remaining count > 0:
- move slot k+1 into slot k;
- write 0 into slot NBYTES-1;
- decrement the tx remaining count.
REQ-026 SHALL ignore tx_shift when tx_empty is high.
REQ-027 SHALL give tx_load priority over tx_shift when both are asserted in the same cycle.
REQ-028 SHALL allow an accepted commit and tx_load in the same cycle, with the tx shifter loading the pre-commit config values.
REQ-029 SHALL drive tx_dw, tx_empty, conf_flat and rx_count directly from registers, with no combinational input-to-output paths.

Reset
REQ-030 SHALL, while rst is high, set the following to 0: rx chain, rx_count, config registers, tx slots, tx remaining count, conf_valid, commit_ok and commit_err.
- tx_empty is therefore 1 during reset.
REQ-031 SHALL give rst priority over every strobe; a frame in progress at reset is lost.

Configuration
REQ-032 SHALL provide the checksum feature under macro CONF_REGBANK_CHECKSUM_EN.
- Defined: FLEN = NBYTES+1; stage NBYTES holds the checksum byte.
- Defined: a commit is accepted only if the sum of stages 0..NBYTES, modulo 2^DW, equals 0.
- Undefined: FLEN = NBYTES; no checksum logic is present; the rule always holds.

Verification
REQ-033 SHALL pass this scenario, NBYTES=11 and no macro: send bytes 0x01..0x0B, then commit.
- Required: commit_ok pulses; conf_flat[7:0] = 0x01; conf_flat[87:80] = 0x0B; conf_valid = 1.
REQ-034 SHALL pass this scenario: send 5 bytes, then commit.
- Required: commit_err pulses; conf_flat is unchanged; rx_count = 0.
REQ-035 SHALL pass this scenario: after REQ-033, pulse tx_load, then pulse tx_shift 11 times.
- Required: tx_dw shows 0x01, 0x02, ..., 0x0B, then 0x00; tx_empty = 1 after the 11th shift.
- Required: a 12th tx_shift leaves the state unchanged.
REQ-036 SHALL pass this scenario with the macro defined: send bytes 0x01..0x0B, then checksum 0xBE, then commit.
- Required: commit_ok pulses.
- Repeat with checksum 0xBF: commit_err pulses and conf_flat is unchanged.
REQ-037 SHALL pass this scenario: send 11 bytes, then assert commit and rx_valid (0x55) together.
- Required: commit_ok pulses; rx_count = 1; 0x55 is in stage FLEN-1.
REQ-038 SHALL pass this scenario: assert rst after 6 bytes.
- Required: all outputs are 0 except tx_empty = 1.
- Required: a following 11-byte frame commits correctly.
